ethernet_sfp_link_ctrl: RTL and testbench

Multi-lane link bring-up and supervision controller for SFP/QSFP 10G Ethernet ports, running on the free-running 125 MHz clock. It generalises the single-port power-on reset timer to LANES ports. Per lane it sequences GT reset, waits for PCS block lock, debounces lock into link_up, and retries with an RX datapath reset on lock timeout or loss. It also reports per-lane status and retry counts.

---
 rtl/ethernet_sfp_link_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_ethernet_sfp_link_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_sfp_link_ctrl.sv
// Multi-lane SFP/GT link bring-up controller: global GT reset sequencing plus
// per-lane lock qualification, retry with RX datapath reset, and status reporting.
module ethernet_sfp_link_ctrl #(
    parameter int LANES               = 1,
    parameter int RESET_CYCLES        = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1250000,
    parameter int STABLE_CYCLES       = 12500,
    parameter int RX_RESET_CYCLES     = 16,
    parameter int MAX_RETRIES         = 0
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 clock_ok,
    input  logic [LANES-1:0]     sfp_modprs_n,
    input  logic [LANES-1:0]     gt_reset_tx_done,
    input  logic [LANES-1:0]     gt_reset_rx_done,
    input  logic [LANES-1:0]     rx_block_lock,
    output logic                 gt_reset_all,
    output logic                 sfp_refclk_reset,
    output logic [LANES-1:0]     gt_rx_datapath_reset,
    output logic [LANES-1:0]     link_up,
    output logic [LANES-1:0]     link_change,
    output logic [8*LANES-1:0]   lane_status
);

    localparam int TMAX = (LOCK_TIMEOUT_CYCLES > STABLE_CYCLES)
        ? ((LOCK_TIMEOUT_CYCLES > RX_RESET_CYCLES) ? LOCK_TIMEOUT_CYCLES : RX_RESET_CYCLES)
        : ((STABLE_CYCLES > RX_RESET_CYCLES) ? STABLE_CYCLES : RX_RESET_CYCLES);
    localparam int TW = $clog2(TMAX) + 1;
    localparam int GW = $clog2(RESET_CYCLES) + 1;

    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] RXRST_LAST  = TW'(RX_RESET_CYCLES - 1);
    localparam logic [GW-1:0] GRST_LAST   = GW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_WAIT_GT   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_UP        = 3'd4,
        ST_RETRY     = 3'd5,
        ST_FAILED    = 3'd6
    } lane_state_e;

    logic             clock_ok_meta, clock_ok_sync;
    logic [LANES-1:0] modprs_meta, modprs_sync;
    logic [LANES-1:0] tx_meta, tx_sync;
    logic [LANES-1:0] rx_meta, rx_sync;
    logic [LANES-1:0] lock_meta, lock_sync;
    logic [GW-1:0]    gcnt;

    // Module-present resets to "absent" so lanes never start before a real sample.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clock_ok_meta <= 1'b0;
            clock_ok_sync <= 1'b0;
            modprs_meta   <= '1;
            modprs_sync   <= '1;
            tx_meta       <= '0;
            tx_sync       <= '0;
            rx_meta       <= '0;
            rx_sync       <= '0;
            lock_meta     <= '0;
            lock_sync     <= '0;
        end else begin
            clock_ok_meta <= clock_ok;
            clock_ok_sync <= clock_ok_meta;
            modprs_meta   <= sfp_modprs_n;
            modprs_sync   <= modprs_meta;
            tx_meta       <= gt_reset_tx_done;
            tx_sync       <= tx_meta;
            rx_meta       <= gt_reset_rx_done;
            rx_sync       <= rx_meta;
            lock_meta     <= rx_block_lock;
            lock_sync     <= lock_meta;
        end
    end

    assign sfp_refclk_reset = ~clock_ok_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gcnt         <= '0;
            gt_reset_all <= 1'b1;
        end else if (!clock_ok_sync) begin
            gcnt         <= '0;
            gt_reset_all <= 1'b1;
        end else if (gt_reset_all) begin
            if (gcnt == GRST_LAST) begin
                gt_reset_all <= 1'b0;
            end else begin
                gcnt <= gcnt + GW'(1);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_state_e   state;
        logic [TW-1:0] timer;
        logic [3:0]    retry;
        logic          rx_rst;
        logic          up_q;
        logic          up_d;
        logic          change_q;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                state    <= ST_OFF;
                timer    <= '0;
                retry    <= '0;
                rx_rst   <= 1'b0;
                up_q     <= 1'b0;
                up_d     <= 1'b0;
                change_q <= 1'b0;
            end else begin
                up_q     <= (state == ST_UP);
                up_d     <= up_q;
                change_q <= up_q ^ up_d;

                // Removal outranks clock loss, which outranks every FSM transition.
                if (modprs_sync[i] || !clock_ok_sync) begin
                    state  <= ST_OFF;
                    timer  <= '0;
                    retry  <= '0;
                    rx_rst <= 1'b0;
                end else begin
                    case (state)
                        ST_OFF: begin
                            timer  <= '0;
                            retry  <= '0;
                            rx_rst <= 1'b0;
                            if (!gt_reset_all) state <= ST_WAIT_GT;
                        end
                        ST_WAIT_GT: begin
                            timer <= '0;
                            if (tx_sync[i] && rx_sync[i]) state <= ST_WAIT_LOCK;
                        end
                        ST_WAIT_LOCK: begin
                            if (lock_sync[i]) begin
                                state <= ST_STABLE;
                                timer <= '0;
                            end else if (timer == LOCK_LAST) begin
                                state  <= ST_RETRY;
                                timer  <= '0;
                                rx_rst <= 1'b1;
                                if (retry != 4'hF) retry <= retry + 4'd1;
                            end else begin
                                timer <= timer + TW'(1);
                            end
                        end
                        ST_STABLE: begin
                            if (!lock_sync[i]) begin
                                state <= ST_WAIT_LOCK;
                                timer <= '0;
                            end else if (timer == STABLE_LAST) begin
                                state <= ST_UP;
                                timer <= '0;
                            end else begin
                                timer <= timer + TW'(1);
                            end
                        end
                        ST_UP: begin
                            if (!lock_sync[i] || !rx_sync[i]) begin
                                state  <= ST_RETRY;
                                timer  <= '0;
                                rx_rst <= 1'b1;
                                if (retry != 4'hF) retry <= retry + 4'd1;
                            end
                        end
                        ST_RETRY: begin
                            if (timer == RXRST_LAST) begin
                                timer  <= '0;
                                rx_rst <= 1'b0;
                                if ((MAX_RETRIES != 0) && (int'(retry) >= MAX_RETRIES)) begin
                                    state <= ST_FAILED;
                                end else begin
                                    state <= ST_WAIT_GT;
                                end
                            end else begin
                                timer <= timer + TW'(1);
                            end
                        end
                        ST_FAILED: begin
                            timer  <= '0;
                            rx_rst <= 1'b0;
                        end
                        default: begin
                            state  <= ST_OFF;
                            timer  <= '0;
                            rx_rst <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign gt_rx_datapath_reset[i] = rx_rst;
        assign link_up[i]              = up_q;
        assign link_change[i]          = change_q;
        assign lane_status[8*i +: 8]   = {state == ST_FAILED, retry, state};
    end

endmodule

// File: tb/tb_ethernet_sfp_link_ctrl.sv
// Directed bench for ethernet_sfp_link_ctrl: vector table for lane-0 bring-up and
// hand sequences for timeout retries, hot-unplug and clock loss.
module tb_ethernet_sfp_link_ctrl;

    logic        clock;
    logic        resetn;
    logic        clock_ok;
    logic [1:0]  sfp_modprs_n;
    logic [1:0]  gt_reset_tx_done;
    logic [1:0]  gt_reset_rx_done;
    logic [1:0]  rx_block_lock;
    logic        gt_reset_all;
    logic        sfp_refclk_reset;
    logic [1:0]  gt_rx_datapath_reset;
    logic [1:0]  link_up;
    logic [1:0]  link_change;
    logic [15:0] lane_status;

    int passed = 0;
    int total  = 0;

    ethernet_sfp_link_ctrl #(
        .LANES(2), .RESET_CYCLES(16), .LOCK_TIMEOUT_CYCLES(100),
        .STABLE_CYCLES(20), .RX_RESET_CYCLES(16), .MAX_RETRIES(3)
    ) dut (
        .clock(clock), .resetn(resetn), .clock_ok(clock_ok),
        .sfp_modprs_n(sfp_modprs_n), .gt_reset_tx_done(gt_reset_tx_done),
        .gt_reset_rx_done(gt_reset_rx_done), .rx_block_lock(rx_block_lock),
        .gt_reset_all(gt_reset_all), .sfp_refclk_reset(sfp_refclk_reset),
        .gt_rx_datapath_reset(gt_rx_datapath_reset), .link_up(link_up),
        .link_change(link_change), .lane_status(lane_status)
    );

    initial clock = 1'b0;
    always #4 clock = ~clock;

    typedef struct {
        logic [1:0]  modprs_n;
        logic [1:0]  tx;
        logic [1:0]  rx;
        logic [1:0]  lock;
        int          cycles;
        logic [15:0] status;
        logic [1:0]  lu;
        logic [1:0]  lc;
        logic [1:0]  rxr;
    } vec_t;

    vec_t vecs[16];

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        int rises[3];
        int falls[3];
        int nr;
        int nf;
        int t_hit;
        int t_gra;
        logic prev;

        resetn           = 1'b0;
        clock_ok         = 1'b0;
        sfp_modprs_n     = 2'b11;
        gt_reset_tx_done = 2'b00;
        gt_reset_rx_done = 2'b00;
        rx_block_lock    = 2'b00;

        // modprs, tx, rx, lock, cycles, status{l1,l0}, link_up, link_change, rx_reset
        vecs[0]  = '{2'b10, 2'b01, 2'b01, 2'b00,  6, 16'h0002, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{2'b10, 2'b01, 2'b01, 2'b01,  4, 16'h0003, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{2'b10, 2'b01, 2'b01, 2'b00,  5, 16'h0002, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{2'b10, 2'b01, 2'b01, 2'b01,  3, 16'h0003, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{2'b10, 2'b01, 2'b01, 2'b01, 19, 16'h0003, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{2'b10, 2'b01, 2'b01, 2'b01,  1, 16'h0004, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{2'b10, 2'b01, 2'b01, 2'b01,  1, 16'h0004, 2'b01, 2'b00, 2'b00};
        vecs[7]  = '{2'b10, 2'b01, 2'b01, 2'b01,  1, 16'h0004, 2'b01, 2'b01, 2'b00};
        vecs[8]  = '{2'b10, 2'b01, 2'b01, 2'b01,  1, 16'h0004, 2'b01, 2'b00, 2'b00};
        vecs[9]  = '{2'b10, 2'b01, 2'b01, 2'b00,  3, 16'h000D, 2'b01, 2'b00, 2'b01};
        vecs[10] = '{2'b10, 2'b01, 2'b01, 2'b00,  1, 16'h000D, 2'b00, 2'b00, 2'b01};
        vecs[11] = '{2'b10, 2'b01, 2'b01, 2'b00,  1, 16'h000D, 2'b00, 2'b01, 2'b01};
        vecs[12] = '{2'b10, 2'b01, 2'b01, 2'b01, 14, 16'h0009, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{2'b10, 2'b01, 2'b01, 2'b01,  2, 16'h000B, 2'b00, 2'b00, 2'b00};
        vecs[14] = '{2'b10, 2'b01, 2'b01, 2'b01, 20, 16'h000C, 2'b00, 2'b00, 2'b00};
        vecs[15] = '{2'b10, 2'b01, 2'b01, 2'b01,  2, 16'h000C, 2'b01, 2'b01, 2'b00};

        // Reset values
        step(3);
        check("rst_gt_reset_all", 32'(gt_reset_all), 32'd1);
        check("rst_refclk_reset", 32'(sfp_refclk_reset), 32'd1);
        check("rst_rx_reset", 32'(gt_rx_datapath_reset), 32'd0);
        check("rst_link_up", 32'(link_up), 32'd0);
        check("rst_link_change", 32'(link_change), 32'd0);
        check("rst_status", 32'(lane_status), 32'd0);

        // Global sequence
        resetn = 1'b1;
        step(10);
        clock_ok = 1'b1;
        step(1);
        check("refclk_reset_1cyc", 32'(sfp_refclk_reset), 32'd1);
        step(1);
        check("refclk_reset_2cyc", 32'(sfp_refclk_reset), 32'd0);
        step(15);
        check("gt_reset_all_17cyc", 32'(gt_reset_all), 32'd1);
        step(1);
        check("gt_reset_all_18cyc", 32'(gt_reset_all), 32'd0);
        check("absent_lanes_off", 32'(lane_status), 32'd0);

        // Lane 0 bring-up, STABLE glitch, UP lock loss and relock
        for (int i = 0; i < 16; i++) begin
            sfp_modprs_n     = vecs[i].modprs_n;
            gt_reset_tx_done = vecs[i].tx;
            gt_reset_rx_done = vecs[i].rx;
            rx_block_lock    = vecs[i].lock;
            step(vecs[i].cycles);
            check($sformatf("v%0d_status", i), 32'(lane_status), 32'(vecs[i].status));
            check($sformatf("v%0d_link_up", i), 32'(link_up), 32'(vecs[i].lu));
            check($sformatf("v%0d_link_change", i), 32'(link_change), 32'(vecs[i].lc));
            check($sformatf("v%0d_rx_reset", i), 32'(gt_rx_datapath_reset), 32'(vecs[i].rxr));
        end

        // Lane 1 lock timeout: three retry pulses then FAILED
        sfp_modprs_n     = 2'b00;
        gt_reset_tx_done = 2'b11;
        gt_reset_rx_done = 2'b11;
        rx_block_lock    = 2'b01;
        nr = 0;
        nf = 0;
        for (int i = 0; i < 3; i++) begin
            rises[i] = -1;
            falls[i] = -1;
        end
        prev = 1'b0;
        for (int t = 1; t <= 400; t++) begin
            step(1);
            if (gt_rx_datapath_reset[1] && !prev) begin
                if (nr < 3) rises[nr] = t;
                nr++;
            end
            if (!gt_rx_datapath_reset[1] && prev) begin
                if (nf < 3) falls[nf] = t;
                nf++;
            end
            prev = gt_rx_datapath_reset[1];
        end
        check("timeout_pulse_count", 32'(nr), 32'd3);
        check("timeout_first_rise", 32'(rises[0]), 32'd104);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("timeout_width%0d", i), 32'(falls[i] - rises[i]), 32'd16);
        end
        check("timeout_spacing1", 32'(rises[1] - rises[0]), 32'd117);
        check("timeout_spacing2", 32'(rises[2] - rises[1]), 32'd117);
        check("failed_status_l1", 32'(lane_status[15:8]), 32'h9E);
        check("failed_l0_status", 32'(lane_status[7:0]), 32'h0C);
        check("failed_l0_link_up", 32'(link_up[0]), 32'd1);

        // Removal clears FAILED
        sfp_modprs_n = 2'b10;
        step(3);
        check("unplug_failed_status", 32'(lane_status[15:8]), 32'h00);

        // Hot-unplug in the middle of a retry pulse
        sfp_modprs_n = 2'b00;
        t_hit = -1;
        for (int t = 1; t <= 200; t++) begin
            step(1);
            if (gt_rx_datapath_reset[1]) begin
                t_hit = t;
                break;
            end
        end
        check("replug_retry_rise", 32'(t_hit), 32'd104);
        step(5);
        sfp_modprs_n = 2'b10;
        t_hit = -1;
        for (int t = 1; t <= 10; t++) begin
            step(1);
            if (!gt_rx_datapath_reset[1]) begin
                t_hit = t;
                break;
            end
        end
        check("unplug_rx_reset_fall", 32'(t_hit), 32'd3);
        check("unplug_l1_status", 32'(lane_status[15:8]), 32'h00);
        check("unplug_l0_status", 32'(lane_status[7:0]), 32'h0C);
        check("unplug_l0_link_up", 32'(link_up), 32'b01);

        // Both lanes up, then clock_ok loss and full re-bring-up
        sfp_modprs_n  = 2'b00;
        rx_block_lock = 2'b11;
        step(30);
        check("both_up_link_up", 32'(link_up), 32'b11);
        check("both_up_status", 32'(lane_status), 32'h040C);
        clock_ok = 1'b0;
        step(2);
        check("loss_gt_reset_all_2cyc", 32'(gt_reset_all), 32'd0);
        check("loss_refclk_reset_2cyc", 32'(sfp_refclk_reset), 32'd1);
        step(1);
        check("loss_gt_reset_all_3cyc", 32'(gt_reset_all), 32'd1);
        check("loss_status_off", 32'(lane_status), 32'h0000);
        check("loss_link_up_3cyc", 32'(link_up), 32'b11);
        step(1);
        check("loss_link_up_4cyc", 32'(link_up), 32'b00);
        check("loss_link_change_4cyc", 32'(link_change), 32'b00);
        step(1);
        check("loss_link_change_5cyc", 32'(link_change), 32'b11);
        step(1);
        check("loss_link_change_6cyc", 32'(link_change), 32'b00);

        clock_ok = 1'b1;
        t_hit = -1;
        t_gra = -1;
        for (int t = 1; t <= 200; t++) begin
            step(1);
            if (!gt_reset_all && t_gra < 0) t_gra = t;
            if (link_up == 2'b11) begin
                t_hit = t;
                break;
            end
        end
        check("rebringup_gt_reset_all", 32'(t_gra), 32'd18);
        check("rebringup_link_up", 32'(t_hit), 32'd42);
        check("rebringup_status", 32'(lane_status), 32'h0404);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
